// File: rtl/booth_csa_accum_pkg.sv
// Radix-4 Booth digit encoding and the operand-width relation shared by
// the booth_csa_accum slice.
package booth_csa_accum_pkg;

  localparam int N_DEFAULT = 16;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_dig_e;

  function automatic int ndig_of(input int n);
    return n / 2;
  endfunction

  // Window bits are {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_dig_e booth_decode(input logic [2:0] win);
    booth_dig_e d;
    case (win)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product row: selects 0/A/2A, shifts it to the
// digit position and one's-complements it for negative digits.
module booth_pp_gen
  import booth_csa_accum_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int SW = 3
) (
  input  logic [2*N-1:0] a_i,
  input  logic [2:0]     digit_i,
  input  logic [SW-1:0]  shift_i,
  output logic [2*N-1:0] pp_o,
  output logic           neg_o
);

  booth_dig_e     dig;
  logic [2*N-1:0] mag;
  logic [2*N-1:0] shifted;

  always_comb begin
    dig   = booth_decode(digit_i);
    mag   = '0;
    neg_o = 1'b0;
    case (dig)
      POS1: mag = a_i;
      POS2: mag = a_i << 1;
      NEG1: begin
        mag   = a_i;
        neg_o = 1'b1;
      end
      NEG2: begin
        mag   = a_i << 1;
        neg_o = 1'b1;
      end
      default: mag = '0;
    endcase
    shifted = mag << {shift_i, 1'b0};
    // The +1 completing the negation is injected into carry bit 0 by the CSA row.
    pp_o = neg_o ? ~shifted : shifted;
  end

endmodule

// File: rtl/booth_csa_accum.sv
// Sequential radix-4 Booth multiplier front end: one digit per cycle into a
// 3:2 carry-save accumulator, result left in redundant sum/carry form.
//
// state  | meaning
// IDLE   | in_ready=1, waiting for operands
// RUN    | retiring Booth digit cnt_q into the CSA accumulator
// DONE   | out_valid=1, sum_out/carry_out held until out_ready
module booth_csa_accum
  import booth_csa_accum_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] sum_out,
  output logic [2*N-1:0] carry_out
);

  localparam int NDIG = ndig_of(N);
  localparam int W    = 2 * N;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] a_q, a_d;
  logic [N:0]   b_q, b_d;
  logic [W-1:0] s_q, s_d;
  logic [W-1:0] c_q, c_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] carry_q, carry_d;

  logic [2:0]   digit;
  logic [W-1:0] pp;
  logic         neg;
  logic [W-1:0] maj;
  logic [W-1:0] s_nxt;
  logic [W-1:0] c_nxt;

  assign digit = b_q[{cnt_q, 1'b0} +: 3];

  booth_pp_gen #(
    .N  (N),
    .SW (CW)
  ) u_pp_gen (
    .a_i     (a_q),
    .digit_i (digit),
    .shift_i (cnt_q),
    .pp_o    (pp),
    .neg_o   (neg)
  );

  assign s_nxt = s_q ^ c_q ^ pp;
  assign maj   = (s_q & c_q) | (s_q & pp) | (c_q & pp);
  assign c_nxt = {maj[W-2:0], neg};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = {{N{a_in[N-1]}}, a_in};
          b_d     = {b_in, 1'b0};
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        s_d   = s_nxt;
        c_d   = c_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NDIG - 1)) begin
          sum_d   = s_nxt;
          carry_d = c_nxt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum_out   = sum_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_booth_csa_accum.sv
// Self-checking bench for booth_csa_accum: directed products, backpressure,
// mid-run reset and randomised back-to-back traffic against a scoreboard.
module tb_booth_csa_accum;

  localparam int N = 16;
  localparam int W = 32;
  localparam int NDIG = N / 2;
  localparam int TIMEOUT = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic [W-1:0] carry_out;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] sb_q[$];

  always #5 clk = ~clk;

  booth_csa_accum #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .carry_out (carry_out)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [W-1:0] ax;
    logic [W-1:0] bx;
    ax = {{N{a[N-1]}}, a};
    bx = {{N{b[N-1]}}, b};
    return ax * bx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for a single cycle, then wait (bounded) for out_valid.
  task automatic issue_and_wait(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [W-1:0] exp, output int lat,
                                output bit rdy_seen, output bit ok);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    sb_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    a_in     = N'($urandom);
    b_in     = N'($urandom);
    lat      = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < TIMEOUT) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    ok = out_valid;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (sum_out !== '0) $display("FAIL reset_sum_out: got %h want 0", sum_out);
    else n_pass++;
    n_checks++;
    if (carry_out !== '0) $display("FAIL reset_carry_out: got %h want 0", carry_out);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [N-1:0] ta[4] = '{16'h0003, 16'hFFF9, 16'h8000, 16'h7FFF};
    logic [N-1:0] tb[4] = '{16'h0005, 16'h0006, 16'h8000, 16'h8000};
    logic [W-1:0] te[4] = '{32'h0000000F, 32'hFFFFFFD6, 32'h40000000, 32'hC0008000};
    int lat;
    bit rdy_seen;
    bit ok;
    logic [W-1:0] exp;
    logic [W-1:0] got;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL dir%0d_ready_before: got %b want 1", k, in_ready);
      else n_pass++;
      issue_and_wait(ta[k], tb[k], te[k], lat, rdy_seen, ok);
      exp = sb_q.pop_front();
      n_checks++;
      if (!ok) $display("FAIL dir%0d_timeout: no out_valid within %0d cycles", k, TIMEOUT);
      else n_pass++;
      n_checks++;
      if (lat !== NDIG) $display("FAIL dir%0d_latency: got %0d want %0d", k, lat, NDIG);
      else n_pass++;
      n_checks++;
      if (rdy_seen || in_ready !== 1'b0)
        $display("FAIL dir%0d_ready_busy: in_ready high during RUN/DONE (seen=%0b now=%b) want 0", k, rdy_seen, in_ready);
      else n_pass++;
      got = sum_out + carry_out;
      n_checks++;
      if (got !== exp) $display("FAIL dir%0d_product: got %h want %h", k, got, exp);
      else n_pass++;
      release_out();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL dir%0d_release: out_valid=%b in_ready=%b want 0/1", k, out_valid, in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] a = 16'd1234;
    logic [N-1:0] b = 16'hFDC9;  // -567
    logic [W-1:0] exp;
    logic [W-1:0] got;
    int lat;
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    sb_q.push_back(ref_mul(a, b));
    tick();
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < TIMEOUT) begin
      // Stray in_valid and out_ready during RUN must be ignored.
      in_valid  = (lat == 2 || lat == 5);
      out_ready = (lat == 3);
      a_in      = 16'd7777;
      b_in      = 16'd3;
      tick();
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp = sb_q.pop_front();
    n_checks++;
    if (lat !== NDIG) $display("FAIL bp_latency: got %0d want %0d", lat, NDIG);
    else n_pass++;
    for (int h = 0; h < 5; h++) begin
      got = sum_out + carry_out;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== exp)
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b sum=%h want 1/0/%h", h, out_valid, in_ready, got, exp);
      else n_pass++;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    got = sum_out + carry_out;
    n_checks++;
    if (out_valid !== 1'b1 || got !== exp)
      $display("FAIL bp_hold_end: out_valid=%b sum=%h want 1/%h", out_valid, got, exp);
    else n_pass++;
    release_out();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_idle_stays: in_ready=%b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit rdy_seen;
    bit ok;
    logic [W-1:0] exp;
    logic [W-1:0] got;
    in_valid = 1'b1;
    a_in     = 16'd100;
    b_in     = 16'd100;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum_out !== '0 || carry_out !== '0)
      $display("FAIL midrst_state: in_ready=%b out_valid=%b sum=%h carry=%h want 1/0/0/0",
               in_ready, out_valid, sum_out, carry_out);
    else n_pass++;
    issue_and_wait(16'd2, 16'd2, 32'h00000004, lat, rdy_seen, ok);
    exp = sb_q.pop_front();
    got = sum_out + carry_out;
    n_checks++;
    if (!ok || lat !== NDIG) $display("FAIL midrst_after_latency: got %0d want %0d", lat, NDIG);
    else n_pass++;
    n_checks++;
    if (got !== exp) $display("FAIL midrst_after_product: got %h want %h", got, exp);
    else n_pass++;
    release_out();
  endtask

  task automatic test_random_back_to_back(input int nvec);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [W-1:0] exp;
    logic [W-1:0] got;
    int lat;
    bit rdy_seen;
    bit ok;
    int hold;
    for (int v = 0; v < nvec; v++) begin
      case ($urandom_range(0, 7))
        0: a = 16'h8000;
        1: a = 16'h7FFF;
        2: a = 16'hFFFF;
        default: a = N'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: b = 16'h8000;
        1: b = 16'h7FFF;
        2: b = 16'h0000;
        default: b = N'($urandom);
      endcase
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL rnd%0d_ready: got %b want 1", v, in_ready);
      else n_pass++;
      issue_and_wait(a, b, ref_mul(a, b), lat, rdy_seen, ok);
      exp = sb_q.pop_front();
      got = sum_out + carry_out;
      n_checks++;
      if (!ok || lat !== NDIG || rdy_seen)
        $display("FAIL rnd%0d_timing: lat=%0d ready_seen=%0b want %0d/0", v, lat, rdy_seen, NDIG);
      else n_pass++;
      n_checks++;
      if (got !== exp) $display("FAIL rnd%0d_product: a=%h b=%h got %h want %h", v, a, b, got, exp);
      else n_pass++;
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      for (int h = 0; h < hold; h++) tick();
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random_back_to_back(2000);
    n_checks++;
    if (sb_q.size() !== 0) $display("FAIL scoreboard_drain: %0d entries left want 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
